// File: rtl/approx_mult_pkg.sv
// Shared constants and the bit-level reference for the approximate multiplier.
//   MAX_WIDTH / MAX_STAGES : legal parameter limits for approx_mult_pipe
//   approx_ref()           : H|L product (high columns summed, low columns OR-ed)
package approx_mult_pkg;

    localparam int unsigned MAX_WIDTH  = 32;
    localparam int unsigned MAX_STAGES = 4;
    localparam int unsigned MAX_PW     = 2 * MAX_WIDTH;

    // Columns >= cols are summed with full carry; columns < cols are OR-reduced
    // and never carry into column cols. cols = 0 yields the exact product.
    function automatic logic [MAX_PW-1:0] approx_ref(input logic [MAX_WIDTH-1:0] a,
                                                     input logic [MAX_WIDTH-1:0] b,
                                                     input int unsigned          cols);
        logic [MAX_PW-1:0] hi;
        logic [MAX_PW-1:0] lo;
        hi = '0;
        lo = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            for (int unsigned k = 0; k < MAX_WIDTH; k++) begin
                if (a[i] && b[k]) begin
                    if (i + k >= cols) hi = hi + (MAX_PW'(1) << (i + k));
                    else               lo = lo | (MAX_PW'(1) << (i + k));
                end
            end
        end
        return hi | lo;
    endfunction

endpackage

// File: rtl/approx_mult_pipe_pp_reduce.sv
// Combinational reduction of the WIDTH x WIDTH partial-product matrix.
//   a_i, b_i   : unsigned operands
//   approx_i   : 1 = low APPROX_COLS columns leave the adder tree
//   sum_o      : carry-save sum vector   (product = sum_o + carry_o | or_o)
//   carry_o    : carry-save carry vector
//   or_o       : per-column OR of the low columns, zero in exact mode
module pp_reduce
    import approx_mult_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned APPROX_COLS = 8
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               approx_i,
    output logic [2*WIDTH-1:0] sum_o,
    output logic [2*WIDTH-1:0] carry_o,
    output logic [2*WIDTH-1:0] or_o
);

    localparam int unsigned PW = 2 * WIDTH;
    // Columns that stay in the adder tree in approximate mode.
    localparam logic [PW-1:0] HIGH_MASK = ~((PW'(1) << APPROX_COLS) - PW'(1));

    logic [PW-1:0] row;
    logic [PW-1:0] keep;
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    logic [PW-1:0] s_n;
    logic [PW-1:0] c_n;
    logic [PW-1:0] lo;

    // Carry-save array: each partial-product row is folded into (s, c) by a
    // row of full adders. Masked low columns are all-zero, so no carry can be
    // born below APPROX_COLS; carries past the top bit are zero for a valid
    // product and are dropped.
    always_comb begin
        row  = '0;
        s    = '0;
        c    = '0;
        s_n  = '0;
        c_n  = '0;
        lo   = '0;
        keep = approx_i ? HIGH_MASK : '1;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            row = b_i[k] ? (PW'(a_i) << k) : '0;
            lo  = lo | row;
            row = row & keep;
            s_n = s ^ c ^ row;
            c_n = ((s & c) | (s & row) | (c & row)) << 1;
            s   = s_n;
            c   = c_n;
        end
        sum_o   = s;
        carry_o = c;
        or_o    = approx_i ? (lo & ~HIGH_MASK) : '0;
    end

endmodule

// File: rtl/approx_mult_pipe.sv
// Pipelined unsigned multiplier with per-transaction exact/approximate mode.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake (in_ready = pipeline can advance)
//   in_a, in_b           : unsigned operands
//   in_approx            : 1 = approximate product for this transaction
//   out_valid/out_ready  : product handshake, held stable under backpressure
//   out_p, out_approx    : product and the mode tag that travelled with it
//   cnt_clr, approx_cnt  : saturating count of accepted approximate operations
// Stage 1 holds the carry-save vectors, stage 2 the resolved product, and
// further stages just delay it; with PIPE_STAGES = 1 the whole product is
// resolved before the single register.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned APPROX_COLS = 8,
    parameter int unsigned PIPE_STAGES = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_approx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               out_approx,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   approx_cnt
);

    localparam int unsigned PW = 2 * WIDTH;

    if (WIDTH < 4 || WIDTH > MAX_WIDTH || APPROX_COLS > 2 * WIDTH - 1 ||
        PIPE_STAGES == 0 || PIPE_STAGES > MAX_STAGES) begin : g_param_err
        $error("approx_mult_pipe: illegal WIDTH/APPROX_COLS/PIPE_STAGES");
    end

    logic                   advance_c;
    logic                   accept_c;
    logic [PIPE_STAGES-1:0] vld_q, vld_d;
    logic [PIPE_STAGES-1:0] apx_q, apx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]          red_sum, red_carry, red_or;
    logic [PW-1:0]          prod_out;

    pp_reduce #(
        .WIDTH       (WIDTH),
        .APPROX_COLS (APPROX_COLS)
    ) u_pp_reduce (
        .a_i      (in_a),
        .b_i      (in_b),
        .approx_i (in_approx),
        .sum_o    (red_sum),
        .carry_o  (red_carry),
        .or_o     (red_or)
    );

    // Whole pipeline moves as one; it can move whenever the output slot frees.
    assign advance_c = out_ready | ~vld_q[PIPE_STAGES-1];
    assign accept_c  = in_valid & advance_c;

    // Next state for valid/mode shift chain and the approximate-op counter.
    always_comb begin
        vld_d = vld_q;
        apx_d = apx_q;
        cnt_d = cnt_q;
        if (advance_c) begin
            vld_d[0] = in_valid;
            apx_d[0] = in_approx;
            for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
                apx_d[i] = apx_q[i-1];
            end
        end
        // Clear takes priority over a coincident increment.
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (accept_c && in_approx && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            apx_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            apx_q <= apx_d;
            cnt_q <= cnt_d;
        end
    end

    if (PIPE_STAGES == 1) begin : g_single
        logic [PW-1:0] prod_q;

        // Resolve the carry-save vectors before the only register.
        always_ff @(posedge clk) begin
            if (rst)            prod_q <= '0;
            else if (advance_c) prod_q <= (red_sum + red_carry) | red_or;
        end
        assign prod_out = prod_q;
    end else begin : g_split
        logic [PW-1:0] sum_q, carry_q, or_q;
        logic [PW-1:0] prod_q [PIPE_STAGES-1];

        // Stage 1 keeps carry-save form; stage 2 does the final add.
        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q   <= '0;
                carry_q <= '0;
                or_q    <= '0;
                for (int unsigned i = 0; i < PIPE_STAGES - 1; i++) prod_q[i] <= '0;
            end else if (advance_c) begin
                sum_q     <= red_sum;
                carry_q   <= red_carry;
                or_q      <= red_or;
                prod_q[0] <= (sum_q + carry_q) | or_q;
                for (int unsigned i = 1; i < PIPE_STAGES - 1; i++) prod_q[i] <= prod_q[i-1];
            end
        end
        assign prod_out = prod_q[PIPE_STAGES-2];
    end

    assign in_ready   = advance_c;
    assign out_valid  = vld_q[PIPE_STAGES-1];
    assign out_approx = apx_q[PIPE_STAGES-1];
    assign out_p      = prod_out;
    assign approx_cnt = cnt_q;

    // The reduction tree must agree with the bit-level reference on accept.
    always @(posedge clk) begin
        if (!rst && accept_c) begin
            assert (((red_sum + red_carry) | red_or) ==
                    (in_approx ? PW'(approx_ref(MAX_WIDTH'(in_a), MAX_WIDTH'(in_b), APPROX_COLS))
                               : PW'(in_a) * PW'(in_b)));
        end
    end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe (WIDTH=8, APPROX_COLS=4,
// PIPE_STAGES=3, CNT_W=4) against an arithmetic reference model.
module tb_approx_mult_pipe;

    localparam int unsigned W  = 8;
    localparam int unsigned AC = 4;
    localparam int unsigned PS = 3;
    localparam int unsigned CW = 4;
    localparam int unsigned PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_approx;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_p;
    logic          out_approx;
    logic          cnt_clr;
    logic [CW-1:0] approx_cnt;

    int errors  = 0;
    int checks  = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    approx_mult_pipe #(
        .WIDTH       (W),
        .APPROX_COLS (AC),
        .PIPE_STAGES (PS),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_approx  (in_approx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_p      (out_p),
        .out_approx (out_approx),
        .cnt_clr    (cnt_clr),
        .approx_cnt (approx_cnt)
    );

    // Reference product: exact product minus the low-column contribution,
    // with the low columns replaced by their per-column OR.
    function automatic logic [PW-1:0] model_p(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic apx);
        int unsigned full;
        int unsigned low;
        int unsigned lor;
        full = 32'(a) * 32'(b);
        low  = 0;
        lor  = 0;
        if (!apx) return PW'(full);
        for (int i = 0; i < W; i++)
            for (int k = 0; k < W; k++)
                if (a[i] && b[k] && (i + k) < AC) begin
                    low = low + (32'd1 << (i + k));
                    lor = lor | (32'd1 << (i + k));
                end
        return PW'((full - low) | lor);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: fixed-latency delay line that only moves when the output slot frees.
    logic          m_v [PS];
    logic [PW-1:0] m_p [PS];
    logic          m_a [PS];
    logic [CW-1:0] m_cnt;
    logic          m_adv;

    always_comb m_adv = out_ready || !m_v[PS-1];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PS; i++) m_v[i] <= 1'b0;
            m_cnt <= '0;
        end else begin
            if (cnt_clr) m_cnt <= '0;
            else if (in_valid && m_adv && in_approx && m_cnt != '1) m_cnt <= m_cnt + 1'b1;
            if (m_adv) begin
                for (int i = 1; i < PS; i++) begin
                    m_v[i] <= m_v[i-1];
                    m_p[i] <= m_p[i-1];
                    m_a[i] <= m_a[i-1];
                end
                m_v[0] <= in_valid;
                m_p[0] <= model_p(in_a, in_b, in_approx);
                m_a[0] <= in_approx;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", 32'(out_valid), 32'(m_v[PS-1]));
            chk("in_ready", 32'(in_ready), 32'(out_ready || !m_v[PS-1]));
            if (m_v[PS-1]) begin
                chk("out_p", 32'(out_p), 32'(m_p[PS-1]));
                chk("out_approx", 32'(out_approx), 32'(m_a[PS-1]));
            end
            chk("approx_cnt", 32'(approx_cnt), 32'(m_cnt));
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic apx);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_approx = apx;
    endtask

    task automatic drive_rand(input logic v);
        drive(v, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    logic [PW-1:0] held_p;

    initial begin
        rst = 1'b1; out_ready = 1'b1; cnt_clr = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; started = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_p", 32'(out_p), 32'd0);
        chk("rst_cnt", 32'(approx_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Hand-computed products, each due three cycles after acceptance.
        @(posedge clk); #1 drive(1'b1, 8'hFF, 8'hFF, 1'b0);
        @(posedge clk); #1 drive(1'b1, 8'hFF, 8'hFF, 1'b1);
        @(posedge clk); #1 drive(1'b1, 8'h03, 8'h03, 1'b1);
        @(posedge clk); #1 drive(1'b1, 8'h03, 8'h03, 1'b0);
        @(negedge clk);
        chk("lit_ff_exact_valid", 32'(out_valid), 32'd1);
        chk("lit_ff_exact", 32'(out_p), 32'h0000FE01);
        chk("lit_ff_exact_tag", 32'(out_approx), 32'd0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("lit_ff_approx", 32'(out_p), 32'h0000FDDF);
        chk("lit_ff_approx_tag", 32'(out_approx), 32'd1);
        @(posedge clk); @(negedge clk);
        chk("lit_33_approx", 32'(out_p), 32'h00000007);
        @(posedge clk); @(negedge clk);
        chk("lit_33_exact", 32'(out_p), 32'h00000009);
        chk("lit_cnt_2", 32'(approx_cnt), 32'd2);
        idle(3);

        // Back-to-back random stream with no backpressure.
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1 drive_rand(1'b1);
        end
        idle(5);

        // Fill, then stall for five cycles.
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1 drive_rand(1'b1);
        end
        @(posedge clk); #1 out_ready = 1'b0; drive_rand(1'b1);
        @(negedge clk) held_p = out_p;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_hold_p", 32'(out_p), 32'(held_p));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        idle(6);

        // Random traffic with random backpressure and occasional clears.
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            drive_rand(1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 15) == 0);
        end
        @(posedge clk); #1 out_ready = 1'b1; cnt_clr = 1'b0;
        idle(6);

        // Reset with three transactions in flight.
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1 drive(1'b1, W'($urandom), W'($urandom), 1'b1);
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_p", 32'(out_p), 32'd0);
        chk("midrst_cnt", 32'(approx_cnt), 32'd0);
        idle(8);

        // Counter saturation, then clear racing an approximate accept.
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1 drive(1'b1, W'($urandom), W'($urandom), 1'b1);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("cnt_saturated", 32'(approx_cnt), 32'd15);
        @(posedge clk); #1 drive(1'b1, 8'h5A, 8'hC3, 1'b1); cnt_clr = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);
        chk("cnt_clear_wins", 32'(approx_cnt), 32'd0);
        idle(6);
        @(negedge clk);
        chk("drained", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
